// File: rtl/adc_capture_mc_if.sv
// Signal bundle between the multi-channel ADC capture front end and its
// control/sample-storage side. The capture block uses the slave view.
interface adc_capture_mc_if #(
    parameter int DATA_W = 12,
    parameter int NUM_CH = 2,
    parameter int DEC_W  = 8,
    parameter int AL_W   = 3
);
    logic                     en;
    logic [1:0]               conv_mode;
    logic                     avg_en;
    logic [AL_W-1:0]          avg_log2;
    logic [DEC_W-1:0]         dec_ratio;
    logic                     ovr_clr;
    logic [NUM_CH*DATA_W-1:0] adc_data_in;
    logic [NUM_CH-1:0]        adc_clk_out;
    logic [NUM_CH*DATA_W-1:0] adc_data_out;
    logic                     adc_valid;
    logic [NUM_CH-1:0]        overrange;

    modport master (
        output en, conv_mode, avg_en, avg_log2, dec_ratio, ovr_clr, adc_data_in,
        input  adc_clk_out, adc_data_out, adc_valid, overrange
    );

    modport slave (
        input  en, conv_mode, avg_en, avg_log2, dec_ratio, ovr_clr, adc_data_in,
        output adc_clk_out, adc_data_out, adc_valid, overrange
    );
endinterface

// File: rtl/adc_capture_mc.sv
// Multi-channel parallel-ADC capture: raw register, code conversion, then
// shared-window pick or power-of-two boxcar decimation with sticky over-range.
module adc_capture_mc #(
    parameter int DATA_W       = 12,
    parameter int NUM_CH       = 2,
    parameter int DEC_W        = 8,
    parameter int AVG_MAX_LOG2 = 4,
    parameter int AL_W         = 3
) (
    input  logic            ad_clk,
    input  logic            sys_rst_n,
    adc_capture_mc_if.slave bus
);
    localparam int ACC_W = DATA_W + AVG_MAX_LOG2;
    localparam int CNT_W = (DEC_W > AVG_MAX_LOG2) ? DEC_W : AVG_MAX_LOG2;
    localparam int CFG_W = 2 + 1 + AL_W + DEC_W;
    localparam logic [DATA_W-1:0] MID_C    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [AL_W-1:0]   AL_MAX_C = AL_W'(AVG_MAX_LOG2);
    localparam logic [CNT_W-1:0]  CNT_ONE_C = CNT_W'(1'b1);

    function automatic logic [DATA_W-1:0] conv_f(input logic [DATA_W-1:0] x,
                                                 input logic [1:0]        mode);
        logic [DATA_W-1:0] y;
        case (mode)
            2'd1:    y = MID_C - x;
            2'd2:    y = {~x[DATA_W-1], x[DATA_W-2:0]};
            default: y = x;
        endcase
        return y;
    endfunction

    function automatic logic ovr_f(input logic [DATA_W-1:0] x);
        return (x == {DATA_W{1'b0}}) || (x == {DATA_W{1'b1}});
    endfunction

    logic [DATA_W-1:0] s1_r      [NUM_CH];
    logic [DATA_W-1:0] s2_r      [NUM_CH];
    logic [ACC_W-1:0]  acc_r     [NUM_CH];
    logic [DATA_W-1:0] out_r     [NUM_CH];
    logic              valid_r;
    logic [NUM_CH-1:0] ovr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CFG_W-1:0]  cfg_prev_r;

    logic [CFG_W-1:0]  cfg_s;
    logic              cfg_chg_s;
    logic [AL_W-1:0]   l_eff_s;
    logic [CNT_W-1:0]  idx_s;
    logic [CNT_W-1:0]  win_last_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              last_s;
    logic              emit_s;
    logic              signed_s;
    logic [NUM_CH-1:0] det_s;
    logic [ACC_W-1:0]  sum_s     [NUM_CH];
    logic [DATA_W-1:0] avg_out_s [NUM_CH];

    // Shared window position: a config change restarts the window at this sample.
    always_comb begin
        cfg_s     = {bus.conv_mode, bus.avg_en, bus.avg_log2, bus.dec_ratio};
        cfg_chg_s = (cfg_s != cfg_prev_r);
        signed_s  = (bus.conv_mode == 2'd2);
        if (bus.avg_log2 > AL_MAX_C) begin
            l_eff_s = AL_MAX_C;
        end else begin
            l_eff_s = bus.avg_log2;
        end
        if (cfg_chg_s) begin
            idx_s = {CNT_W{1'b0}};
        end else begin
            idx_s = cnt_r;
        end
        if (bus.avg_en) begin
            win_last_s = (CNT_ONE_C << l_eff_s) - CNT_ONE_C;
        end else begin
            win_last_s = CNT_W'(bus.dec_ratio);
        end
        last_s = (idx_s == win_last_s);
        if (bus.avg_en) begin
            emit_s = last_s;
        end else begin
            emit_s = (idx_s == {CNT_W{1'b0}});
        end
        if (last_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = idx_s + CNT_ONE_C;
        end
    end

    // Per-channel running sum including the current sample, and its scaled mean.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            det_s[c] = ovr_f(bus.adc_data_in[c*DATA_W +: DATA_W]);
            if (cfg_chg_s) begin
                sum_s[c] = {{AVG_MAX_LOG2{s2_r[c][DATA_W-1] & signed_s}}, s2_r[c]};
            end else begin
                sum_s[c] = acc_r[c] + {{AVG_MAX_LOG2{s2_r[c][DATA_W-1] & signed_s}}, s2_r[c]};
            end
            if (signed_s) begin
                avg_out_s[c] = DATA_W'($signed(sum_s[c]) >>> l_eff_s);
            end else begin
                avg_out_s[c] = DATA_W'(sum_s[c] >> l_eff_s);
            end
        end
    end

    // Pipeline, window counter, accumulators, outputs and sticky flags.
    always_ff @(posedge ad_clk) begin
        if (!sys_rst_n) begin
            valid_r    <= 1'b0;
            ovr_r      <= {NUM_CH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            cfg_prev_r <= {CFG_W{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                s1_r[c]  <= {DATA_W{1'b0}};
                s2_r[c]  <= {DATA_W{1'b0}};
                acc_r[c] <= {ACC_W{1'b0}};
                out_r[c] <= {DATA_W{1'b0}};
            end
        end else begin
            cfg_prev_r <= cfg_s;
            ovr_r      <= (ovr_r & ~{NUM_CH{bus.ovr_clr}}) | det_s;
            for (int c = 0; c < NUM_CH; c++) begin
                s1_r[c] <= bus.adc_data_in[c*DATA_W +: DATA_W];
                s2_r[c] <= conv_f(s1_r[c], bus.conv_mode);
            end
            if (bus.en) begin
                cnt_r   <= cnt_nxt_s;
                valid_r <= emit_s;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (emit_s) begin
                        out_r[c] <= bus.avg_en ? avg_out_s[c] : s2_r[c];
                    end
                    if (bus.avg_en && !last_s) begin
                        acc_r[c] <= sum_s[c];
                    end else begin
                        acc_r[c] <= {ACC_W{1'b0}};
                    end
                end
            end else begin
                cnt_r   <= {CNT_W{1'b0}};
                valid_r <= 1'b0;
                for (int c = 0; c < NUM_CH; c++) begin
                    acc_r[c] <= {ACC_W{1'b0}};
                end
            end
        end
    end

    // Repack per-channel results onto the output bus.
    always_comb begin
        bus.adc_data_out = {(NUM_CH*DATA_W){1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            bus.adc_data_out[c*DATA_W +: DATA_W] = out_r[c];
        end
    end

    assign bus.adc_clk_out = {NUM_CH{ad_clk}};
    assign bus.adc_valid   = valid_r;
    assign bus.overrange   = ovr_r;
endmodule
